// File: rtl/ha_array_mul_sequencer.sv
// Sequencer for the 8x8 approximate multiplier's half-adder stage: latches operands,
// reduces the four row pairs into a saturated 16-bit product with one shared adder.
module ha_array_mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  pp_x,
    output logic [7:0]  pp_y,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_sat,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int unsigned ROWS  = 4;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned ACC_W = OUT_W + 2;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_t;

    state_t             state;
    logic [1:0]         r;
    logic [ACC_W-1:0]   acc;
    logic [8:0]         t_sel;
    logic [6:0]         b_sel;
    logic [9:0]         row_val;
    logic [ACC_W-1:0]   row_term;

    always_comb begin
        t_sel = '0;
        b_sel = '0;
        unique case (r)
            2'd0: begin t_sel = ha_array_0_t; b_sel = ha_array_0_b; end
            2'd1: begin t_sel = ha_array_1_t; b_sel = ha_array_1_b; end
            2'd2: begin t_sel = ha_array_2_t; b_sel = ha_array_2_b; end
            2'd3: begin t_sel = ha_array_3_t; b_sel = ha_array_3_b; end
            default: ;
        endcase
        // Carry vector sits two bit positions above the sum vector within a row.
        row_val  = {1'b0, t_sel} + {1'b0, b_sel, 2'b00};
        row_term = {{(ACC_W-10){1'b0}}, row_val} << {r, 1'b0};
    end

    assign out_sat = |acc[ACC_W-1:OUT_W];
    assign out_p   = out_sat ? {OUT_W{1'b1}} : acc[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            r         <= '0;
            acc       <= '0;
            pp_x      <= '0;
            pp_y      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        pp_x     <= in_x;
                        pp_y     <= in_y;
                        acc      <= '0;
                        r        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_x == 8'd0 || in_y == 8'd0) begin
                            state     <= StDone;
                            out_valid <= 1'b1;
                        end else begin
                            state <= StAcc;
                        end
                    end
                end
                StAcc: begin
                    acc <= acc + row_term;
                    r   <= r + 2'd1;
                    if (r == 2'(ROWS - 1)) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        op_count  <= op_count + 16'd1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ha_array_mul_sequencer.sv
// Directed bench for ha_array_mul_sequencer; row vectors are driven directly by the bench.
module tb_ha_array_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x, in_y;
    logic [7:0]  pp_x, pp_y;
    logic [8:0]  t0, t1, t2, t3;
    logic [6:0]  b0, b1, b2, b3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        out_sat;
    logic        busy;
    logic [15:0] op_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    ha_array_mul_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .pp_x         (pp_x),
        .pp_y         (pp_y),
        .ha_array_0_t (t0),
        .ha_array_1_t (t1),
        .ha_array_2_t (t2),
        .ha_array_3_t (t3),
        .ha_array_0_b (b0),
        .ha_array_1_b (b1),
        .ha_array_2_b (b2),
        .ha_array_3_b (b3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_p        (out_p),
        .out_sat      (out_sat),
        .busy         (busy),
        .op_count     (op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rows(input logic [8:0] t, input logic [6:0] b);
        t0 = t; t1 = t; t2 = t; t3 = t;
        b0 = b; b1 = b; b2 = b; b3 = b;
    endtask

    task automatic accept(input logic [7:0] x, input logic [7:0] y);
        chk("in_ready_before_accept", in_ready, 1'b1);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Starting in cycle 1 after acceptance, wait for out_valid with a bound.
    task automatic wait_valid(input int exp_lat);
        int n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", n, exp_lat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("op_count", op_count, exp_cnt);
        chk("out_valid_after_hs", out_valid, 1'b0);
        chk("in_ready_after_hs", in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b0;
        exp_cnt = '0;
        set_rows(9'd0, 7'd0);
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_p", out_p, 16'd0);
        chk("rst_out_sat", out_sat, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pp_x", pp_x, 8'd0);
        chk("rst_pp_y", pp_y, 8'd0);
        chk("rst_op_count", op_count, 16'd0);

        // Abort during ACC at r=2 (cycle 3); op_count must stay at its prior value 0.
        set_rows(9'd1, 7'd1);
        accept(8'd9, 8'd11);
        step();
        step();
        chk("abort_busy_acc", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_op_count", op_count, 16'd0);
        chk("abort_out_p", out_p, 16'd0);

        // Zero shortcut.
        set_rows(9'd0, 7'd0);
        accept(8'd0, 8'd200);
        chk("zero_out_valid_c1", out_valid, 1'b1);
        chk("zero_out_p", out_p, 16'd0);
        chk("zero_out_sat", out_sat, 1'b0);
        chk("zero_pp_y", pp_y, 8'd200);
        handshake();

        // 3x5 with t_0=5: per-cycle checks through ACC, product in cycle 5.
        t0 = 9'd5;
        accept(8'd3, 8'd5);
        for (int c = 1; c <= 4; c++) begin
            chk("acc_busy", busy, 1'b1);
            chk("acc_out_valid", out_valid, 1'b0);
            chk("acc_in_ready", in_ready, 1'b0);
            chk("acc_pp_x", pp_x, 8'd3);
            chk("acc_pp_y", pp_y, 8'd5);
            step();
        end
        chk("c5_out_valid", out_valid, 1'b1);
        chk("c5_busy", busy, 1'b1);
        chk("c5_out_p", out_p, 16'd5);
        chk("c5_out_sat", out_sat, 1'b0);
        handshake();

        // t_3=1 and b_0=1: 1<<6 + 1<<2.
        set_rows(9'd0, 7'd0);
        t3 = 9'd1;
        b0 = 7'd1;
        accept(8'd17, 8'd33);
        wait_valid(5);
        chk("mix_out_p", out_p, 16'd68);
        chk("mix_out_sat", out_sat, 1'b0);
        handshake();

        // All rows maximal: 1019*85 = 86615 saturates.
        set_rows(9'h1FF, 7'h7F);
        accept(8'd255, 8'd255);
        wait_valid(5);
        chk("max_out_p", out_p, 16'hFFFF);
        chk("max_out_sat", out_sat, 1'b1);
        handshake();

        // Back-pressure in DONE while in_valid pulses; no acceptance may occur.
        set_rows(9'd2, 7'd1);
        accept(8'd2, 8'd4);
        wait_valid(5);
        chk("bp_out_p", out_p, 16'd510);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_x = 8'd7;
            in_y = 8'd9;
            step();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_p_stable", out_p, 16'd510);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_pp_x", pp_x, 8'd2);
            chk("bp_op_count", op_count, exp_cnt);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_pp_x_after", pp_x, 8'd2);
        step();
        chk("bp_single_hs", op_count, exp_cnt);
        chk("bp_idle", busy, 1'b0);

        // Preload op_count to 16'hFFFF with back-to-back zero-shortcut operations.
        in_x = 8'd0;
        in_y = 8'd1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * (65535 - int'(exp_cnt)); i++) step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_cnt = 16'hFFFF;
        chk("preload_op_count", op_count, 16'hFFFF);
        accept(8'd0, 8'd0);
        wait_valid(1);
        handshake();
        chk("wrap_op_count", op_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
